// File: rtl/mul_add_seq.sv
// mul_add_seq: sequential radix-2 shift-add multiply-accumulate, P = A*B + C, unsigned.
//
// It also serves as the companion of the sequential divider. Feeding it the
// quotient as A, the divisor as B and the remainder as C rebuilds the dividend
// in P, which lets divider results be self-checked.
//
// Ports:
//   clk    rising-edge clock for all state
//   reset  asynchronous, active-high; clears all state and abandons any operation
//   start  request, accepted only while busy is low; A, B and C are captured on that edge
//   A      multiplier operand (WIDTH bits)
//   B      multiplicand operand (WIDTH bits)
//   C      addend (WIDTH bits), zero-extended to 2*WIDTH
//   P      result A*B+C (2*WIDTH bits), held from done until the next accepted start
//   busy   high while an operation is in progress (RUN and ADD)
//   done   one-cycle pulse when P becomes valid
//   ovf    high when the upper half of P is nonzero; registered together with P
//
// Timing: a start accepted at edge E0 runs WIDTH multiply steps (E1..E_WIDTH),
// then one add edge (E_WIDTH+1) that loads P and pulses done. A start in the
// cycle where done is high is accepted immediately.
module mul_add_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [WIDTH-1:0]   C,
  output logic [2*WIDTH-1:0] P,
  output logic               busy,
  output logic               done,
  output logic               ovf
);

  // The iteration counter counts WIDTH-1 down to 0. Keep it at least one bit
  // wide so that a degenerate WIDTH still elaborates.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] COUNT_START = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ADD  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Working registers. {acc_hi, acc_lo} is the 2*WIDTH partial product.
  // acc_lo starts out holding the multiplier, and its bit 0 picks whether
  // mcand is added on each step.
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   addend;
  logic [CW-1:0]      count;

  // Control strobes decoded from the state.
  logic               load;
  logic               step;
  logic               finish;

  // Datapath intermediates.
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] result;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        // The step on the count==0 edge is the last of WIDTH steps.
        if (count == '0) begin
          state_next = ADD;
        end
      end
      ADD: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

  // Conditional add of the multiplicand. The carry is kept in sum[WIDTH]
  // so that it shifts into the top bit of acc_hi and is not lost.
  always_comb begin
    sum = {1'b0, acc_hi};
    if (acc_lo[0]) begin
      sum = {1'b0, acc_hi} + {1'b0, mcand};
    end
  end

  // The final product plus the zero-extended addend cannot exceed 2*WIDTH
  // bits: the largest value is (2^W-1)^2 + (2^W-1) = 2^(2W) - 2^W.
  assign result = {acc_hi, acc_lo} + {{WIDTH{1'b0}}, addend};

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_hi <= '0;
      acc_lo <= '0;
      mcand  <= '0;
      addend <= '0;
      count  <= '0;
      P      <= '0;
      ovf    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        acc_hi <= '0;
        acc_lo <= A;
        mcand  <= B;
        addend <= C;
        count  <= COUNT_START;
      end
      if (step) begin
        // Shift {carry, hi, lo} right by one. The multiplier bit that was
        // just consumed falls off the bottom.
        {acc_hi, acc_lo} <= {sum, acc_lo[WIDTH-1:1]};
        count            <= count - 1'b1;
      end
      if (finish) begin
        P    <= result;
        ovf  <= |result[2*WIDTH-1:WIDTH];
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mul_add_seq.sv
// tb_mul_add_seq: directed self-checking bench for mul_add_seq (WIDTH=32).
// Each scenario task drives its own stimulus and compares against
// hand-computed values. A single summary line is printed at the end.
module tb_mul_add_seq;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic          clk;
  logic          reset;
  logic          start;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic [W-1:0]  C;
  logic [2*W-1:0] P;
  logic          busy;
  logic          done;
  logic          ovf;

  int checks;
  int failures;

  mul_add_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .C     (C),
    .P     (P),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request and wait for done. Outputs are sampled 1 time unit
  // after each rising edge. lat counts edges from acceptance to the sample
  // where done is seen. bcnt counts samples with busy high before done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                        output int lat, output int bcnt, output logic to);
    @(negedge clk);
    A = a; B = b; C = c; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    bcnt = busy ? 1 : 0;
    lat = 0;
    to = 1'b0;
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
      if (busy) bcnt++;
      if (lat >= 60) begin
        to = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; A = '0; B = '0; C = '0;
    #12;
    checks++;
    if (P !== '0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_state: P=%h busy=%b done=%b ovf=%b, required all zero", P, busy, done, ovf);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat, bcnt;
    logic to;
    run_op(32'd100, 32'd7, 32'd2, lat, bcnt, to);
    checks++;
    if (to || lat != LAT) begin
      failures++;
      $display("[TB] FAIL basic_latency: got %0d edges (timeout=%b), required %0d", lat, to, LAT);
    end
    checks++;
    if (bcnt != LAT) begin
      failures++;
      $display("[TB] FAIL basic_busy_cycles: got %0d, required %0d", bcnt, LAT);
    end
    checks++;
    if (P !== 64'd702 || ovf !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_result: P=%0d ovf=%b busy=%b, required P=702 ovf=0 busy=0", P, ovf, busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || P !== 64'd702) begin
      failures++;
      $display("[TB] FAIL basic_done_pulse: done=%b P=%0d one edge later, required done=0 P=702", done, P);
    end
  endtask

  task automatic test_max();
    int lat, bcnt;
    logic to;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt, to);
    checks++;
    if (to || P !== 64'hFFFF_FFFF_0000_0000 || ovf !== 1'b1) begin
      failures++;
      $display("[TB] FAIL max_operands: P=%h ovf=%b to=%b, required P=ffffffff00000000 ovf=1", P, ovf, to);
    end
  endtask

  task automatic test_zero();
    int lat, bcnt;
    logic to;
    run_op(32'd0, 32'h1234, 32'h55, lat, bcnt, to);
    checks++;
    if (to || lat != LAT || P !== 64'h55 || ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL zero_operand: P=%h ovf=%b lat=%0d, required P=55 ovf=0 lat=%0d", P, ovf, lat, LAT);
    end
  endtask

  // Quotient and remainder are computed here with / and %. The block must
  // rebuild the dividend in the lower half of P, with the upper half zero.
  task automatic test_divider_check();
    int lat, bcnt;
    logic to;
    logic [W-1:0] a, b, q, r;
    int bad;
    a = 32'hDEAD_BEEF; b = 32'h1234;
    q = a / b; r = a % b;
    run_op(q, b, r, lat, bcnt, to);
    checks++;
    if (to || P !== 64'h0000_0000_DEAD_BEEF || ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL divider_directed: P=%h ovf=%b, required P=00000000deadbeef ovf=0", P, ovf);
    end
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 4 == 1) b = b & 32'h0000_00FF;
      if (i % 4 == 2) b = b & 32'h0000_FFFF;
      if (b == 0) b = 32'd1;
      q = a / b; r = a % b;
      run_op(q, b, r, lat, bcnt, to);
      checks++;
      if (to || P !== {32'd0, a} || ovf !== 1'b0) begin
        failures++;
        bad++;
        if (bad <= 5)
          $display("[TB] FAIL divider_random: a=%h b=%h P=%h ovf=%b, required P=%h ovf=0", a, b, P, ovf, {32'd0, a});
      end
    end
  endtask

  // Hold start high and change the operands every cycle. Only the value on
  // the accepting edge may count. The second request is set up in the done
  // cycle, so it is captured at the edge right after done.
  task automatic test_busy_protect();
    int lat;
    logic seen;
    @(negedge clk);
    A = 32'd10; B = 32'd20; C = 32'd3; start = 1'b1;
    @(posedge clk);
    #1;
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      A = $urandom; B = $urandom; C = $urandom;
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || P !== 64'd203) begin
      failures++;
      $display("[TB] FAIL busy_first_capture: P=%0d seen=%b, required P=203", P, seen);
    end
    A = 32'd6; B = 32'd7; C = 32'd8;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL busy_rearm: busy=%b done=%b after done edge, required busy=1 done=0", busy, done);
    end
    seen = 1'b0;
    lat = 0;
    for (int k = 0; k < 60; k++) begin
      A = $urandom; B = $urandom; C = $urandom;
      @(posedge clk);
      #1;
      lat++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (!seen || lat != LAT || P !== 64'd50) begin
      failures++;
      $display("[TB] FAIL busy_second_capture: P=%0d lat=%0d, required P=50 lat=%0d", P, lat, LAT);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midop();
    int lat, bcnt;
    logic to, late;
    @(negedge clk);
    A = 32'd1000; B = 32'd1000; C = 32'd1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (P !== '0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_midop_async: P=%h busy=%b done=%b ovf=%b, required all zero", P, busy, done, ovf);
    end
    @(negedge clk);
    reset = 1'b0;
    late = 1'b0;
    repeat (45) begin
      @(posedge clk);
      #1;
      if (done || busy) late = 1'b1;
    end
    checks++;
    if (late) begin
      failures++;
      $display("[TB] FAIL reset_no_late_done: saw done/busy after reset, required none");
    end
    run_op(32'd12, 32'd12, 32'd0, lat, bcnt, to);
    checks++;
    if (to || lat != LAT || P !== 64'd144) begin
      failures++;
      $display("[TB] FAIL reset_fresh_op: P=%0d lat=%0d, required P=144 lat=%0d", P, lat, LAT);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    logic to, held, seen;
    run_op(32'd9, 32'd9, 32'd0, lat, bcnt, to);
    checks++;
    if (to || P !== 64'd81) begin
      failures++;
      $display("[TB] FAIL b2b_first: P=%0d, required 81", P);
    end
    A = 32'd3; B = 32'd5; C = 32'd1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || P !== 64'd81) begin
      failures++;
      $display("[TB] FAIL b2b_accept: done=%b busy=%b P=%0d, required done=0 busy=1 P=81", done, busy, P);
    end
    held = 1'b1;
    seen = 1'b0;
    lat = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (P !== 64'd81) held = 1'b0;
    end
    checks++;
    if (!held) begin
      failures++;
      $display("[TB] FAIL b2b_hold: P changed before second done, required 81 held");
    end
    checks++;
    if (!seen || lat != LAT || P !== 64'd16 || ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_second: P=%0d lat=%0d, required P=16 lat=%0d", P, lat, LAT);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_divider_check();
    test_busy_protect();
    test_reset_midop();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_add_seq.md
Name: mul_add_seq

Overview:
- Sequential radix-2 shift-add multiply-accumulate: P = A*B + C, unsigned.
- Inverse companion to the team's sequential divider: given quotient D, divisor B and remainder R, the block reconstructs the dividend A = D*B + R.
- Serves as the datapath multiplier and as the self-check engine for divider results in the SoC arithmetic cluster.
- Single request in flight; start/busy/done handshake.

Parameters:
WIDTH, 32, operand width; product width is 2*WIDTH; iteration counter width is $clog2(WIDTH).

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  request; accepted only while busy=0
A  input  WIDTH  multiplier operand
B  input  WIDTH  multiplicand operand
C  input  WIDTH  addend, zero-extended to 2*WIDTH
P  output  2*WIDTH  result A*B+C; held from done until next accepted start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when P becomes valid
ovf  output  1  high when P[2*WIDTH-1:WIDTH] != 0, i.e. result exceeds WIDTH bits; registered with P

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE; P=0, busy=0, done=0, ovf=0; counter, internal accumulator and operand registers =0.
  - An operation interrupted by reset is abandoned; no done pulse follows.
- Handshake and capture:
  - start is sampled on each edge. If busy=0 at edge E0 and start=1, A, B and C are captured and busy=1 after E0.
  - start while busy=1 is ignored; no queuing.
  - Operand input changes after E0 have no effect on the result.
- States and transitions:
  - IDLE -> RUN on accepted start.
    - acc_hi=0, acc_lo=A, mcand=B, addend=C, count=WIDTH-1.
  - RUN, one step per edge, WIDTH edges (E1..E32 for WIDTH=32):
    - sum[WIDTH:0] = acc_lo[0] ? acc_hi + mcand : {1'b0, acc_hi} (WIDTH+1 bits, carry kept).
    - {acc_hi, acc_lo} <= {sum, acc_lo[WIDTH-1:1]}, i.e. the full {carry, hi, lo} shifts right 1.
    - count decrements. At the edge where count==0, the step is performed and the next state is ADD.
  - ADD, one edge (E33 for WIDTH=32):
    - P <= {acc_hi, acc_lo} + {0, addend}.
    - ovf <= upper half of that sum != 0.
    - done <= 1; busy <= 0; next state IDLE.
  - IDLE: done returns to 0 on the next edge (E34). P and ovf hold.
- Latency: start accepted at E0, done=1 and P valid in the cycle after E(WIDTH+1), i.e. WIDTH+1 edges (33 for WIDTH=32). Throughput is one result per WIDTH+2 cycles.
- Back-to-back: start=1 in the cycle where done=1 is accepted at that next edge, since busy=0. done falls and busy rises on the same edge, and P keeps its old value until the new ADD.
- Width rule: max result (2^W-1)^2 + (2^W-1) = 2^(2W) - 2^W fits in 2*WIDTH bits. No carry beyond P; no saturation.
- Zero operands are not special-cased: A=0 or B=0 still takes full latency and yields P=C.
- busy is 1 in RUN and ADD, 0 in IDLE.

Test Plan:
- Basic: A=100, B=7, C=2, start 1 cycle -> busy for 33 cycles, done pulse exactly 33 edges after accept, P=702, ovf=0.
- Max operands: A=B=C=0xFFFFFFFF -> P=0xFFFFFFFF_00000000, ovf=1. Zero case: A=0, B=0x1234, C=0x55 -> P=0x55, ovf=0, full latency.
- Divider cross-check: A=0xDEADBEEF divided by B=0x1234 on the divider; feed D, B=0x1234, C=R -> P=0x00000000_DEADBEEF, ovf=0. Repeat for 1000 random A/B with B!=0.
- Busy protection: start held high continuously and operands changed every cycle during RUN -> only the first capture is used. Next op begins at the edge after done; P matches the captured operands each time.
- Reset mid-op: assert reset 10 cycles after start -> P=0, busy=0, done=0 immediately (asynchronous). No later done pulse. A fresh start after reset yields the correct result.
- Back-to-back: start=1 in the done cycle with new operands A=3, B=5, C=1 -> accepted, P holds the previous result for 33 cycles, then P=16.
